// File: rtl/gate_tt_checker.sv
// gate_tt_checker
//   Stimulus-and-check wrapper around a 2-input gate under test. Sweeps the
//   gate inputs {a,b} through 00, 01, 10, 11. Each vector is held for
//   SETTLE_CYCLES cycles, then sampled for one cycle. The sampled y is
//   compared with the truth table of the latched gate type, and pass, an
//   error count and a per-vector fail map are reported.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous active-high reset
//   start_i      one-cycle sweep request; honoured only in IDLE/DONE with gate_sel_i <= 5
//   gate_sel_i   0 AND, 1 OR, 2 NAND, 3 NOR, 4 XOR, 5 XNOR (6/7 reserved)
//   y_i          output of the gate under test
//   a_o, b_o     registered gate inputs
//   busy_o       sweep in progress
//   done_o       sweep finished; holds until the next accepted start or reset
//   pass_o       done with zero mismatches
//   err_count_o  number of mismatching vectors (0..4)
//   fail_vec_o   bit i set when vector {a,b}==i mismatched
//
// state  | meaning
// IDLE   | waiting for a valid start, outputs cleared
// SETTLE | holding the current vector while the gate output settles
// SAMPLE | comparing y with the expected value for the current vector
// DONE   | results valid and held, waiting for a restart
module gate_tt_checker #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [2:0] gate_sel_i,
  input  logic       y_i,
  output logic       a_o,
  output logic       b_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic [2:0] err_count_o,
  output logic [3:0] fail_vec_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // With no settle window every vector goes straight to its sampling cycle.
  localparam state_t VEC_ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;
  localparam logic [3:0] SETTLE_LAST =
    (SETTLE_CYCLES == 0) ? 4'd0 : 4'(SETTLE_CYCLES - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic [2:0] sel_q;
  logic       a_q, b_q;
  logic       busy_q, done_q, pass_q;
  logic [2:0] err_q;
  logic [3:0] fail_q;

  logic       expected;
  logic       mismatch;
  logic [2:0] err_d;
  logic [3:0] fail_d;

  always_comb begin
    expected = 1'b0;
    unique case (sel_q)
      3'd0:    expected =   idx_q[1] & idx_q[0];
      3'd1:    expected =   idx_q[1] | idx_q[0];
      3'd2:    expected = ~(idx_q[1] & idx_q[0]);
      3'd3:    expected = ~(idx_q[1] | idx_q[0]);
      3'd4:    expected =   idx_q[1] ^ idx_q[0];
      3'd5:    expected = ~(idx_q[1] ^ idx_q[0]);
      default: expected = 1'b0;
    endcase
    mismatch = (y_i != expected);
    err_d    = err_q + {2'b00, mismatch};
    fail_d   = fail_q | (mismatch ? (4'b0001 << idx_q) : 4'b0000);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      sel_q   <= 3'd0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_i && (gate_sel_i <= 3'd5)) begin
            sel_q   <= gate_sel_i;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= VEC_ENTRY;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_q   <= 4'd0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        SAMPLE: begin
          err_q  <= err_d;
          fail_q <= fail_d;
          if (idx_q == 2'd3) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Uses the count including this last compare.
            pass_q  <= (err_d == 3'd0);
            state_q <= DONE;
          end else begin
            idx_q        <= idx_q + 2'd1;
            {a_q, b_q}   <= idx_q + 2'd1;
            cnt_q        <= 4'd0;
            state_q      <= VEC_ENTRY;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign a_o         = a_q;
  assign b_o         = b_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_vec_o  = fail_q;

endmodule

// File: tb/tb_gate_tt_checker.sv
module tb_gate_tt_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] gate_sel;
  logic       y;
  logic       a, b, busy, done, pass;
  logic [2:0] err_count;
  logic [3:0] fail_vec;

  // gate model in the loop
  logic [2:0] model_sel;
  logic       tie0;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;
  logic done_prev = 1'b0;

  typedef struct {
    int err;
    int fv;
    int pass;
    int t_acc;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  gate_tt_checker #(.SETTLE_CYCLES(2)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .gate_sel_i  (gate_sel),
    .y_i         (y),
    .a_o         (a),
    .b_o         (b),
    .busy_o      (busy),
    .done_o      (done),
    .pass_o      (pass),
    .err_count_o (err_count),
    .fail_vec_o  (fail_vec)
  );

  function automatic logic gate_fn(input logic [2:0] s, input logic ga, input logic gb);
    case (s)
      3'd0:    return ga & gb;
      3'd1:    return ga | gb;
      3'd2:    return !(ga & gb);
      3'd3:    return !(ga | gb);
      3'd4:    return ga ^ gb;
      3'd5:    return !(ga ^ gb);
      default: return 1'b0;
    endcase
  endfunction

  always_comb y = tie0 ? 1'b0 : gate_fn(model_sel, a, b);

  task automatic chk(input string name, input int act, input int expv);
    n_total++;
    if (act == expv) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  // Scoreboard monitor: compares on every rising edge of done.
  always @(negedge clk) begin
    if (done && !done_prev) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("err_count", int'(err_count), e.err);
        chk("fail_vec",  int'(fail_vec),  e.fv);
        chk("pass",      int'(pass),      e.pass);
        chk("done_latency", cyc - e.t_acc, 12);
        chk("busy_at_done", int'(busy), 0);
      end
    end
    done_prev = done;
  end

  // Issue a start; when it is expected to be accepted, push its result.
  task automatic pulse_start(input logic [2:0] sel, input bit push,
                             input int e_err, input int e_fv, input int e_pass);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    gate_sel = sel;
    if (push) begin
      e.err = e_err; e.fv = e_fv; e.pass = e_pass; e.t_acc = cyc + 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    gate_sel = 3'd3;   // changes mid-sweep must be ignored
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) chk("done_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst = 1'b1; start = 1'b0; gate_sel = 3'd0; model_sel = 3'd0; tie0 = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ab",   int'({a, b}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pass", int'(pass), 0);
    chk("rst_err",  int'(err_count), 0);
    chk("rst_fail", int'(fail_vec), 0);
    rst = 1'b0;

    // reserved gate_sel is ignored
    pulse_start(3'd7, 0, 0, 0, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    chk("sel7_ignored", seen, 0);

    // correct AND, vector sequence and busy window
    model_sel = 3'd0; tie0 = 1'b0;
    pulse_start(3'd0, 1, 0, 4'b0000, 1);
    for (int k = 1; k <= 12; k++) begin
      if (k == 1)  chk("ab_vec0", int'({a, b}), 0);
      if (k == 4)  chk("ab_vec1", int'({a, b}), 1);
      if (k == 7)  chk("ab_vec2", int'({a, b}), 2);
      if (k == 10) chk("ab_vec3", int'({a, b}), 3);
      if (k == 1)  chk("busy_k1", int'(busy), 1);
      if (k == 11) chk("busy_k11", int'(busy), 1);
      if (k == 11) chk("done_k11", int'(done), 0);
      if (k < 12) @(negedge clk);
    end
    wait_done();

    // y stuck at 0 with AND / OR expected
    tie0 = 1'b1;
    pulse_start(3'd0, 1, 1, 4'b1000, 0);
    wait_done();
    pulse_start(3'd1, 1, 3, 4'b1110, 0);
    wait_done();

    // restart from DONE after failure: results clear, rerun passes
    tie0 = 1'b0; model_sel = 3'd1;
    pulse_start(3'd1, 1, 0, 4'b0000, 1);
    chk("restart_done_clr", int'(done), 0);
    chk("restart_err_clr",  int'(err_count), 0);
    chk("restart_fail_clr", int'(fail_vec), 0);
    chk("restart_busy",     int'(busy), 1);
    wait_done();

    // XOR in loop, XNOR expected
    model_sel = 3'd4;
    pulse_start(3'd5, 1, 4, 4'b1111, 0);
    wait_done();

    // second start at cycle 4 is ignored
    model_sel = 3'd2;
    pulse_start(3'd2, 1, 0, 4'b0000, 1);
    repeat (2) @(negedge clk);
    start = 1'b1; gate_sel = 3'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // reset in the middle of a sweep
    model_sel = 3'd0;
    pulse_start(3'd0, 1, 0, 0, 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("midrst_ab",   int'({a, b}), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_done", int'(done), 0);
    chk("midrst_err",  int'(err_count), 0);
    chk("midrst_fail", int'(fail_vec), 0);
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    chk("midrst_stays_idle", seen, 0);

    // full passing sweep after reset
    model_sel = 3'd3;
    pulse_start(3'd3, 1, 0, 4'b0000, 1);
    wait_done();

    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
